// File: rtl/traffic_ctrl_mc_pkg.sv
// ============================================================================
// traffic_pkg : shared lamp/phase types and width helpers for traffic_ctrl_mc
// Revision    : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        ALL_RED   = 2'd0,
        GREEN_PH  = 2'd1,
        YELLOW_PH = 2'd2,
        PED_PH    = 2'd3
    } phase_t;

    // Never returns 0, so a counter sized for a value of 1 still has a bit.
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_ctrl_mc_if.sv
// ============================================================================
// traffic_ctrl_mc_if : demand inputs and lamp outputs of the controller
// Revision           : 1.0  (ped signals present only with TRAFFIC_PED_EN)
// ============================================================================
`default_nettype none

interface traffic_ctrl_mc_if #(
    parameter int N_DIR = 2
);
    import traffic_pkg::*;

    localparam int AW = clog2_safe(N_DIR);

    logic   [N_DIR-1:0] req;
    light_t [N_DIR-1:0] color;
    logic   [AW-1:0]    active_dir;
    logic               phase_start;

`ifdef TRAFFIC_PED_EN
    logic               ped_req;
    logic               walk;

    modport master (output req, ped_req, input color, active_dir, phase_start, walk);
    modport slave  (input req, ped_req, output color, active_dir, phase_start, walk);
`else
    modport master (output req, input color, active_dir, phase_start);
    modport slave  (input req, output color, active_dir, phase_start);
`endif

endinterface

`default_nettype wire

// File: rtl/traffic_ctrl_mc_rr_pick.sv
// ============================================================================
// traffic_rr_pick : next pending approach after cur (wrapping), plus other-demand flag
// Revision        : 1.0
// ============================================================================
`default_nettype none

module traffic_rr_pick #(
    parameter int N_DIR = 2,
    parameter int AW    = 1
) (
    input  logic [N_DIR-1:0] pend,
    input  logic [AW-1:0]    cur,
    output logic [AW-1:0]    nxt,
    output logic             any_other
);

    logic [N_DIR-1:0] self_mask;
    logic [AW-1:0]    idx;
    logic             found;

    assign self_mask = N_DIR'(1) << cur;
    assign any_other = |(pend & ~self_mask);

    // Searching cur+1 .. cur+N_DIR puts the current approach last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        nxt   = (cur == AW'(N_DIR - 1)) ? '0 : cur + AW'(1);
        for (int k = 1; k <= N_DIR; k++) begin
            idx = AW'((int'(cur) + k) % N_DIR);
            if (!found && pend[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_ctrl_mc.sv
// ============================================================================
// traffic_ctrl_mc : round-robin N-approach light controller, demand-driven green
// Revision        : 1.0  (optional pedestrian phase with TRAFFIC_PED_EN)
// ============================================================================
`default_nettype none

module traffic_ctrl_mc
    import traffic_pkg::*;
#(
    parameter int N_DIR      = 2,
    parameter int GREEN_MIN  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int PED_CYC    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    traffic_ctrl_mc_if.slave bus
);

    localparam int AW = clog2_safe(N_DIR);
    localparam int TW = clog2_safe(max4(GREEN_MIN, YELLOW_CYC, ALLRED_CYC, PED_CYC) + 1);

    localparam logic [TW-1:0] G_LAST  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] AR_LAST = TW'(ALLRED_CYC - 1);
    localparam logic [TW-1:0] P_LAST  = TW'(PED_CYC - 1);

    phase_t             phase, phase_nx;
    logic   [TW-1:0]    timer;
    logic   [AW-1:0]    dir, dir_nx, pick_dir;
    logic   [N_DIR-1:0] pend, pend_nx;
    light_t [N_DIR-1:0] color_nx;
    logic               any_other, enter_green, ped_hold;

    traffic_rr_pick #(
        .N_DIR (N_DIR),
        .AW    (AW)
    ) u_pick (
        .pend      (pend),
        .cur       (dir),
        .nxt       (pick_dir),
        .any_other (any_other)
    );

`ifdef TRAFFIC_PED_EN
    logic ped_pend;
    assign ped_hold = ped_pend;
`else
    assign ped_hold = 1'b0;
`endif

    always_comb begin
        phase_nx = phase;
        case (phase)
            ALL_RED:   if (timer == AR_LAST) phase_nx = GREEN_PH;
            GREEN_PH:  if (timer >= G_LAST && (any_other || ped_hold)) phase_nx = YELLOW_PH;
            YELLOW_PH: if (timer == Y_LAST) phase_nx = ped_hold ? PED_PH : ALL_RED;
            PED_PH:    if (timer == P_LAST) phase_nx = ALL_RED;
            default:   phase_nx = ALL_RED;
        endcase
    end

    assign enter_green = (phase == ALL_RED) && (phase_nx == GREEN_PH);
    assign dir_nx      = enter_green ? pick_dir : dir;

    // Demand on the approach being served (or about to be) is absorbed.
    always_comb begin
        pend_nx = pend | bus.req;
        if (enter_green)
            pend_nx[pick_dir] = 1'b0;
        else if (phase == GREEN_PH)
            pend_nx[dir] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < N_DIR; i++) color_nx[i] = RED;
        if (phase_nx == GREEN_PH)
            color_nx[dir_nx] = GREEN;
        else if (phase_nx == YELLOW_PH)
            color_nx[dir_nx] = YELLOW;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase           <= ALL_RED;
            timer           <= '0;
            dir             <= AW'(N_DIR - 1);
            pend            <= '0;
            for (int i = 0; i < N_DIR; i++) bus.color[i] <= RED;
            bus.phase_start <= 1'b0;
        end else begin
            phase           <= phase_nx;
            timer           <= (phase_nx != phase) ? '0 :
                               (&timer ? timer : timer + TW'(1));
            dir             <= dir_nx;
            pend            <= pend_nx;
            bus.color       <= color_nx;
            bus.phase_start <= enter_green;
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_pend <= 1'b0;
            bus.walk <= 1'b0;
        end else begin
            ped_pend <= (phase_nx == PED_PH && phase != PED_PH) ? 1'b0 : (ped_pend | bus.ped_req);
            bus.walk <= (phase_nx == PED_PH);
        end
    end
`endif

    assign bus.active_dir = dir;

endmodule

`default_nettype wire

// File: doc/traffic_ctrl_mc.md
Name: traffic_ctrl_mc

Overview:
- Parametrised multi-approach traffic-light controller with programmable phase timing and demand-driven green extension.
- Serves N_DIR approaches in round-robin order. Exactly one approach can be non-RED at a time.
- Sticky vehicle-request latches decide when green ends and which approach is served next.
- Sits at top of the intersection subsystem and drives per-approach lamp codes.

Parameters:
- N_DIR, 2, number of approaches (>=2).
- GREEN_MIN, 8, minimum green cycles (>=1).
- YELLOW_CYC, 3, yellow duration in cycles (>=1).
- ALLRED_CYC, 2, all-red clearance in cycles (>=1).
- PED_CYC, 6, pedestrian walk duration in cycles (>=1; used only with PED_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  N_DIR  per-approach vehicle demand, level or pulse.
- color  out  N_DIR x light_t  packed lamp code per approach.
- active_dir  out  $clog2(N_DIR)  approach currently owning the phase.
- phase_start  out  1  one-cycle pulse on the first cycle of every GREEN.
- walk  out  1  pedestrian walk lamp (PED_EN only).
- ped_req  in  1  pedestrian button (PED_EN only).

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_n), sampled on posedge clk only.
- Reset values:
  - phase = ALL_RED, timer = 0, active_dir = N_DIR-1, pend = 0.
  - All color = RED, phase_start = 0, walk = 0.
- Phases: ALL_RED -> GREEN -> YELLOW -> ALL_RED.
- Timer:
  - Cleared on every phase entry; increments each cycle.
  - Saturates at all-ones. Width = $clog2(max(GREEN_MIN, YELLOW_CYC, ALLRED_CYC, PED_CYC)+1).
- Outputs are registered:
  - color[active_dir] = GREEN in GREEN and YELLOW in YELLOW; all other approaches RED.
  - All approaches are RED in ALL_RED and PED.
- pend[i]:
  - Set when req[i]=1.
  - Cleared on the cycle GREEN is entered for approach i.
  - Set wins over clear only for approaches other than the one entering GREEN. A req on the entering approach is absorbed.
- ALL_RED exit when timer == ALLRED_CYC-1. Next active_dir:
  - The first i with pend[i]=1, searching (active_dir+1) mod N_DIR upward with wrap.
  - If no pend bit is set, (active_dir+1) mod N_DIR (fixed rotation).
  - phase_start asserts on the first GREEN cycle.
- GREEN exit to YELLOW when timer >= GREEN_MIN-1 and any pend[j]=1 with j != active_dir.
  - Otherwise green holds indefinitely; the timer saturates.
- YELLOW exit to ALL_RED when timer == YELLOW_CYC-1.
- Boundaries:
  - A req arriving on the final GREEN_MIN cycle ends green on the next cycle.
  - Simultaneous requests are served in rotation order.
  - Wrap from N_DIR-1 to 0.
  - Reset asserted mid-phase forces ALL_RED on the next edge regardless of state.
- Sequence from reset with no requests: dir0 GREEN at cycle ALLRED_CYC, then holds green.

Optional Feature:
- Macro TRAFFIC_PED_EN.
- Defined: adds ped_req/walk ports, a PED phase and a sticky ped_pend latch.
  - If ped_pend=1 at YELLOW exit, enter PED (all RED, walk=1) for PED_CYC cycles, then ALL_RED.
  - ped_pend is cleared on PED entry.
  - ped_pend also forces GREEN exit after GREEN_MIN, as other-approach demand does.
- Undefined: no ped ports, no PED state, behaviour exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - typedef enum logic[1:0] light_t {RED=0, GREEN=1, YELLOW=2}.
  - typedef enum phase_t {ALL_RED, GREEN_PH, YELLOW_PH, PED_PH}.
  - Function clog2-safe width helper.
- Sub-module traffic_rr_pick: combinational round-robin next-index selector.
  - Inputs: pend vector, current index.
  - Outputs: next index, any_other.

Test Plan:
- Reset, N_DIR=2, no req -> all RED for 2 cycles; dir0 GREEN at cycle 2 with phase_start pulse; holds GREEN for 50 cycles.
- dir0 green, req[1] pulse at timer=2 -> YELLOW at timer 7 (GREEN_MIN=8), YELLOW 3 cycles, ALL_RED 2 cycles, dir1 GREEN; pend[1] cleared.
- N_DIR=4, active=1, req[0] and req[3] together -> next served dir3 then dir0 (rotation with wrap).
- rst_n low during YELLOW -> next edge all RED, active_dir=N_DIR-1, pend=0.
- req on active approach only during its GREEN -> no phase change; pend stays 0.
- TRAFFIC_PED_EN: ped_req during dir0 green -> after GREEN_MIN+YELLOW, walk=1 for 6 cycles with all RED, then ALL_RED 2 cycles, then dir1 GREEN.
